// File: rtl/wisc_defs.sv
// rtl/wisc_defs.sv - shared opcode constants, FSM state encoding and width defaults
package wisc_defs;

  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } mac_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - saturating wait counter, flags the last allowed BUSY cycle
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_SAT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Expiry is seen during the TIMEOUT-th wait cycle so the abort lands on that edge.
  assign o_expired = (r_cnt == CNT_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage LW/SW responder: req/ack to data memory, stall, load return
module mem_access_ctrl
  import wisc_defs::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_to_reg,
  input  logic              reg_to_mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  mac_state_e r_state;
  mac_state_e w_next;

  logic              w_stall;
  logic              w_accept;
  logic              w_illegal;
  logic              w_done;
  logic              w_abort;
  logic              w_expired;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_vld;
  logic              r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_accept  = 1'b0;
    w_illegal = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_to_reg ^ reg_to_mem) begin
          w_stall  = 1'b1;
          w_accept = 1'b1;
          w_next   = ST_BUSY;
        end else if (mem_to_reg && reg_to_mem) begin
          w_illegal = 1'b1;
          w_next    = ST_RESP;
        end
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          w_done = 1'b1;
          w_next = ST_RESP;
        end else if (w_expired) begin
          w_abort = 1'b1;
          w_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_en      ((r_state == ST_BUSY) && !mem_ack),
    .o_expired (w_expired)
  );

  // Response flags are registered so they appear exactly during the RESP cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_rdata_vld <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rdata_vld <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= reg_to_mem;
        r_mem_addr  <= addr;
        r_mem_wdata <= wdata;
      end
      if (w_illegal) begin
        r_err <= 1'b1;
      end
      if (w_done) begin
        r_mem_req <= 1'b0;
        if (!r_mem_we) begin
          r_rdata     <= mem_rdata;
          r_rdata_vld <= 1'b1;
        end
      end
      if (w_abort) begin
        r_mem_req <= 1'b0;
        r_err     <= 1'b1;
        if (!r_mem_we) begin
          r_rdata <= '0;
        end
      end
    end
  end

  assign stall     = w_stall;
  assign rdata     = r_rdata;
  assign rdata_vld = r_rdata_vld;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
